// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD VRAM arbiter: FSM encoding, read-tag layout
// and default bus widths.
package lcd_pkg;

    typedef enum logic {
        ST_LCD_PRI   = 1'b0,
        ST_MPU_FORCE = 1'b1
    } arb_state_e;

    localparam int TAG_LCD = 0;
    localparam int TAG_MPU = 1;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 8;

    typedef logic [1:0] tag_t;

endpackage

// File: rtl/lcd_vram_tagpipe.sv
// Read-tag delay line: RD_LAT+1 stages of {mpu_rd, lcd_rd} that steer SRAM
// read data back to the requester that issued the read.
module lcd_vram_tagpipe
    import lcd_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage [RD_LAT+1];

    // Clearing every stage drops in-flight reads so no stale rvld escapes reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i <= RD_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[RD_LAT];

endmodule

// File: rtl/lcd_vram_arb.sv
// Single-port VRAM arbiter: LCD refresh fetch has priority, a starvation
// counter forces one MPU slot after STARVE_MAX consecutive LCD wins.
module lcd_vram_arb
    import lcd_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arb_en,
    input  logic          lcd_req,
    input  logic [AW-1:0] lcd_addr,
    output logic          lcd_ack,
    output logic          lcd_rvld,
    output logic [DW-1:0] lcd_rdat,
    input  logic          mpu_req,
    input  logic          mpu_we,
    input  logic [AW-1:0] mpu_addr,
    input  logic [DW-1:0] mpu_wdat,
    output logic          mpu_ack,
    output logic          mpu_rvld,
    output logic [DW-1:0] mpu_rdat,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdat,
    input  logic [DW-1:0] mem_rdat,
    output logic [3:0]    starve_cnt
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [3:0] STARVE_PRE = 4'(STARVE_MAX - 1);

    arb_state_e state;
    logic       lcd_xfer;
    logic       mpu_xfer;
    tag_t       tag_in;
    tag_t       tag_out;

    // Handshake: a requester holds req and its payload until it sees ack; a
    // transfer happens in exactly the cycle where req & ack, and ack is a pure
    // function of req and state so a new transfer may follow every cycle.
    always_comb begin
        lcd_ack = 1'b0;
        mpu_ack = 1'b0;
        if (arb_en) begin
            if (state == ST_LCD_PRI) begin
                lcd_ack = lcd_req;
                mpu_ack = mpu_req & ~lcd_req;
            end else begin
                mpu_ack = mpu_req;
                lcd_ack = lcd_req & ~mpu_req;
            end
        end
    end

    assign lcd_xfer = lcd_req & lcd_ack;
    assign mpu_xfer = mpu_req & mpu_ack;

    // Idle cycles only drop mem_en; address/data/we keep their last values.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_wdat <= '0;
        end else begin
            mem_en <= lcd_xfer | mpu_xfer;
            if (mpu_xfer) begin
                mem_we   <= mpu_we;
                mem_addr <= mpu_addr;
                mem_wdat <= mpu_wdat;
            end else if (lcd_xfer) begin
                mem_we   <= 1'b0;
                mem_addr <= lcd_addr;
            end
        end
    end

    // With arb_en low nothing is granted, so state and count simply hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_LCD_PRI;
            starve_cnt <= '0;
        end else if (arb_en) begin
            case (state)
                ST_LCD_PRI: begin
                    if (mpu_xfer || !mpu_req) begin
                        starve_cnt <= '0;
                    end else if (lcd_xfer) begin
                        if (starve_cnt >= STARVE_PRE) begin
                            starve_cnt <= STARVE_LIM;
                            state      <= ST_MPU_FORCE;
                        end else begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end
                end
                ST_MPU_FORCE: begin
                    if (mpu_xfer || !mpu_req) begin
                        starve_cnt <= '0;
                        state      <= ST_LCD_PRI;
                    end
                end
                default: begin
                    starve_cnt <= '0;
                    state      <= ST_LCD_PRI;
                end
            endcase
        end
    end

    always_comb begin
        tag_in          = '0;
        tag_in[TAG_LCD] = lcd_xfer;
        tag_in[TAG_MPU] = mpu_xfer & ~mpu_we;
    end

    lcd_vram_tagpipe #(
        .RD_LAT(RD_LAT)
    ) u_tagpipe (
        .clk    (clk),
        .rst    (rst),
        .tag_in (tag_in),
        .tag_out(tag_out)
    );

    assign lcd_rvld = tag_out[TAG_LCD];
    assign mpu_rvld = tag_out[TAG_MPU];
    assign lcd_rdat = mem_rdat;
    assign mpu_rdat = mem_rdat;

endmodule
